// File: rtl/rv32_lsu_pkg.sv
// Shared constants and state encoding for the RV32I load/store unit.
package rv32_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/lsu_align_rv32.sv
// Combinational lane logic: load extract/extend, store merge, and access fault decode.
module lsu_align_rv32
  import rv32_lsu_pkg::*;
(
  input  logic        req_we,
  input  logic [2:0]  req_f3,
  input  logic [1:0]  req_lo,
  input  logic [2:0]  f3,
  input  logic [1:0]  lo,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data,
  output logic        fault
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rword[{lo, 3'b000} +: 8];
    half_v = lo[1] ? rword[31:16] : rword[15:0];
    case (f3)
      F3_B:    load_data = {{24{byte_v[7]}}, byte_v};
      F3_H:    load_data = {{16{half_v[15]}}, half_v};
      F3_BU:   load_data = {24'd0, byte_v};
      F3_HU:   load_data = {16'd0, half_v};
      default: load_data = rword;
    endcase
  end

  // Only SB/SH reach the merge path; SW bypasses the read entirely.
  always_comb begin
    merge_data = rword;
    if (f3 == F3_B)
      merge_data[{lo, 3'b000} +: 8] = wdata[7:0];
    else if (f3 == F3_H)
      merge_data[{lo[1], 4'b0000} +: 16] = wdata[15:0];
  end

  always_comb begin
    fault = 1'b0;
    if (req_we) begin
      fault = (req_f3 >= 3'd3) ||
              ((req_f3 == F3_H) && req_lo[0]) ||
              ((req_f3 == F3_W) && (req_lo != 2'b00));
    end else begin
      case (req_f3)
        F3_B, F3_BU: fault = 1'b0;
        F3_H, F3_HU: fault = req_lo[0];
        F3_W:        fault = (req_lo != 2'b00);
        default:     fault = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/lsu_rv32.sv
// RV32I load/store unit: turns byte/half/word ops into word-wide cache reads,
// writes, and read-modify-write sequences, stalling the pipeline until done.
module lsu_rv32
  import rv32_lsu_pkg::*;
#(
  parameter int ADDRW = 3
) (
  input  logic             iCLK,
  input  logic             iRSTn,
  input  logic             iREQ,
  input  logic             iWE,
  input  logic [2:0]       iFUNCT3,
  input  logic [31:0]      iADDR,
  input  logic [31:0]      iWDATA,
  output logic [31:0]      oRDATA,
  output logic             oDONE,
  output logic             oSTALL,
  output logic             oFAULT,
  output logic [ADDRW-1:0] oCADDR,
  output logic [31:0]      oCWDATA,
  output logic             oCRW,
  input  logic [31:0]      iCRDATA,
  input  logic             iCSTALL
);

  state_t            state, nstate;
  logic [ADDRW+1:0]  addr_q;
  logic [2:0]        f3_q;
  logic              we_q;
  logic [31:0]       wdata_q;
  logic [31:0]       wbuf_q;
  logic [31:0]       rdata_q;
  logic              fault_q;

  logic [31:0]       load_data;
  logic [31:0]       merge_data;
  logic              req_fault;
  logic              req_sw;
  logic              unused_hi;

  // Upper address bits alias away by design.
  assign unused_hi = ^iADDR[31:ADDRW+2];
  assign req_sw    = iWE && (iFUNCT3 == F3_W);

  lsu_align_rv32 u_align (
    .req_we     (iWE),
    .req_f3     (iFUNCT3),
    .req_lo     (iADDR[1:0]),
    .f3         (f3_q),
    .lo         (addr_q[1:0]),
    .rword      (iCRDATA),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data),
    .fault      (req_fault)
  );

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wbuf_q  <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state <= nstate;
      case (state)
        S_IDLE: begin
          if (iREQ && !iCSTALL) begin
            addr_q  <= iADDR[ADDRW+1:0];
            f3_q    <= iFUNCT3;
            we_q    <= iWE;
            wdata_q <= iWDATA;
            fault_q <= req_fault;
            if (req_sw && !req_fault)
              wbuf_q <= iWDATA;
          end
        end
        S_RD: begin
          if (!iCSTALL) begin
            if (we_q) wbuf_q  <= merge_data;
            else      rdata_q <= load_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nstate = state;
    case (state)
      S_IDLE: begin
        if (iREQ && !iCSTALL) begin
          if (req_fault)   nstate = S_DONE;
          else if (req_sw) nstate = S_WR;
          else             nstate = S_RD;
        end
      end
      S_RD:    if (!iCSTALL) nstate = we_q ? S_WR : S_DONE;
      S_WR:    if (!iCSTALL) nstate = S_DONE;
      default: nstate = S_IDLE;
    endcase
  end

  // The read address is presented during the request cycle so data is ready in RD.
  assign oCADDR  = (state == S_IDLE && iREQ) ? iADDR[ADDRW+1:2] : addr_q[ADDRW+1:2];
  assign oCWDATA = wbuf_q;
  assign oCRW    = (state != S_WR);
  assign oDONE   = (state == S_DONE);
  assign oFAULT  = (state == S_DONE) && fault_q;
  assign oSTALL  = ((state == S_IDLE) && iREQ) || (state == S_RD) || (state == S_WR);
  assign oRDATA  = rdata_q;

endmodule

// File: tb/tb_lsu_rv32.sv
// Directed bench for lsu_rv32 with a behavioural word cache model.
module tb_lsu_rv32;

  localparam int ADDRW = 3;

  logic             clk    = 1'b0;
  logic             rst_n  = 1'b0;
  logic             req    = 1'b0;
  logic             we     = 1'b0;
  logic [2:0]       f3     = 3'd0;
  logic [31:0]      addr   = '0;
  logic [31:0]      wdata  = '0;
  logic             cstall = 1'b0;
  logic [31:0]      rdata;
  logic             done, stall, fault;
  logic [ADDRW-1:0] caddr;
  logic [31:0]      cwdata;
  logic             crw;
  logic [31:0]      crdata = '0;

  logic [31:0]      mem [8];
  logic             pre_we   = 1'b0;
  logic [2:0]       pre_addr = '0;
  logic [31:0]      pre_data = '0;

  int n_chk  = 0;
  int n_fail = 0;

  int   edges;
  logic flt, saw_wr;

  always #5 clk = ~clk;

  lsu_rv32 #(.ADDRW(ADDRW)) dut (
    .iCLK    (clk),
    .iRSTn   (rst_n),
    .iREQ    (req),
    .iWE     (we),
    .iFUNCT3 (f3),
    .iADDR   (addr),
    .iWDATA  (wdata),
    .oRDATA  (rdata),
    .oDONE   (done),
    .oSTALL  (stall),
    .oFAULT  (fault),
    .oCADDR  (caddr),
    .oCWDATA (cwdata),
    .oCRW    (crw),
    .iCRDATA (crdata),
    .iCSTALL (cstall)
  );

  // Cache: synchronous read data one cycle after address, writes gated by stall.
  always @(posedge clk) begin
    if (pre_we)
      mem[pre_addr] <= pre_data;
    else if (!crw && !cstall)
      mem[caddr] <= cwdata;
    crdata <= mem[caddr];
  end

  task chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task preload(input int idx, input logic [31:0] d);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_addr = idx[2:0];
    pre_data = d;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  task run_op(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
              output int n, output logic fl, output logic wr_seen);
    @(negedge clk);
    we = w; f3 = f; addr = a; wdata = d; req = 1'b1;
    n = 0; fl = 1'b0;
    #1 wr_seen = !crw;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      n++;
      if (!crw) wr_seen = 1'b1;
      if (done) begin
        fl = fault;
        break;
      end
    end
    req = 1'b0;
    @(posedge clk); #1;
    chk("done_pulse", {31'd0, done}, 32'd0);
  endtask

  initial begin
    #12;
    chk("rst_rdata",  rdata,            32'd0);
    chk("rst_done",   {31'd0, done},    32'd0);
    chk("rst_fault",  {31'd0, fault},   32'd0);
    chk("rst_stall",  {31'd0, stall},   32'd0);
    chk("rst_crw",    {31'd0, crw},     32'd1);
    chk("rst_caddr",  {29'd0, caddr},   32'd0);
    chk("rst_cwdata", cwdata,           32'd0);
    @(negedge clk) rst_n = 1'b1;

    preload(0, 32'hCAFEF00D);
    preload(1, 32'h11223344);
    preload(2, 32'h8899AABB);
    preload(3, 32'h00000000);
    for (int i = 4; i < 8; i++) preload(i, 32'h5A5A0000 + i);

    run_op(1'b0, 3'd2, 32'h08, 32'h0, edges, flt, saw_wr);
    chk("lw_lat",   edges,         32'd2);
    chk("lw_data",  rdata,         32'h8899AABB);
    chk("lw_fault", {31'd0, flt},  32'd0);

    run_op(1'b0, 3'd0, 32'h0B, 32'h0, edges, flt, saw_wr);
    chk("lb_data",  rdata, 32'hFFFFFF88);
    run_op(1'b0, 3'd4, 32'h0B, 32'h0, edges, flt, saw_wr);
    chk("lbu_data", rdata, 32'h00000088);
    run_op(1'b0, 3'd1, 32'h0A, 32'h0, edges, flt, saw_wr);
    chk("lh_data",  rdata, 32'hFFFF8899);
    run_op(1'b0, 3'd5, 32'h08, 32'h0, edges, flt, saw_wr);
    chk("lhu_data", rdata, 32'h0000AABB);

    run_op(1'b1, 3'd0, 32'h05, 32'hFFFFFFA5, edges, flt, saw_wr);
    chk("sb_lat",    edges,  32'd3);
    chk("sb_word1",  mem[1], 32'h1122A544);
    chk("sb_word0",  mem[0], 32'hCAFEF00D);
    chk("sb_word2",  mem[2], 32'h8899AABB);
    chk("sb_rdata",  rdata,  32'h0000AABB);

    run_op(1'b0, 3'd2, 32'h06, 32'h0, edges, flt, saw_wr);
    chk("flw_lat",   edges,            32'd1);
    chk("flw_fault", {31'd0, flt},     32'd1);
    chk("flw_crw",   {31'd0, saw_wr},  32'd0);
    chk("flw_word1", mem[1],           32'h1122A544);

    run_op(1'b1, 3'd1, 32'h03, 32'h0000BEEF, edges, flt, saw_wr);
    chk("fsh_lat",   edges,            32'd1);
    chk("fsh_fault", {31'd0, flt},     32'd1);
    chk("fsh_crw",   {31'd0, saw_wr},  32'd0);
    chk("fsh_word0", mem[0],           32'hCAFEF00D);

    run_op(1'b0, 3'd3, 32'h00, 32'h0, edges, flt, saw_wr);
    chk("ff3_lat",   edges,            32'd1);
    chk("ff3_fault", {31'd0, flt},     32'd1);
    chk("ff3_crw",   {31'd0, saw_wr},  32'd0);

    // SW with the cache stalled for three cycles while in WR
    @(negedge clk);
    we = 1'b1; f3 = 3'd2; addr = 32'h0C; wdata = 32'hDEADBEEF; req = 1'b1;
    @(posedge clk); #1;
    chk("sw_wr_crw", {31'd0, crw}, 32'd0);
    cstall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("sw_hold_crw",   {31'd0, crw},   32'd0);
      chk("sw_hold_done",  {31'd0, done},  32'd0);
      chk("sw_hold_caddr", {29'd0, caddr}, 32'd3);
    end
    chk("sw_no_early", mem[3], 32'h00000000);
    cstall = 1'b0;
    @(posedge clk); #1;
    chk("sw_done",  {31'd0, done}, 32'd1);
    chk("sw_word3", mem[3],        32'hDEADBEEF);
    req = 1'b0;
    @(posedge clk); #1;

    // Reset during the WR cycle of an SH
    @(negedge clk);
    we = 1'b1; f3 = 3'd1; addr = 32'h04; wdata = 32'h0000BEEF; req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rsh_in_wr", {31'd0, crw}, 32'd0);
    rst_n = 1'b0;
    req   = 1'b0;
    #1;
    chk("rsh_crw",    {31'd0, crw},   32'd1);
    chk("rsh_done",   {31'd0, done},  32'd0);
    chk("rsh_fault",  {31'd0, fault}, 32'd0);
    chk("rsh_stall",  {31'd0, stall}, 32'd0);
    chk("rsh_rdata",  rdata,          32'd0);
    chk("rsh_caddr",  {29'd0, caddr}, 32'd0);
    chk("rsh_cwdata", cwdata,         32'd0);
    @(posedge clk); #1;
    chk("rsh_word1", mem[1], 32'h1122A544);
    @(negedge clk) rst_n = 1'b1;

    run_op(1'b0, 3'd2, 32'h20, 32'h0, edges, flt, saw_wr);
    chk("alias_lat",  edges, 32'd2);
    chk("alias_data", rdata, 32'hCAFEF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_rv32.md
# lsu_rv32

Load/store unit for the RV32I core. It sits between the MEM pipeline stage and the word-wide data cache, and turns LB/LH/LW/LBU/LHU/SB/SH/SW requests into single-word cache reads and writes. Sub-word stores become read-modify-write sequences, because the cache has no byte enables. The unit extracts and extends load data, flags misaligned or illegal accesses, and stalls the pipeline until each operation completes.

## Interface
- ADDRW, 3, cache word-index width (cache holds 2^ADDRW words)
- iCLK  in  1  clock; all state changes on the rising edge
- iRSTn  in  1  asynchronous, active-low reset
- iREQ  in  1  MEM stage has a memory op; held stable until oDONE
- iWE  in  1  1 = store, 0 = load
- iFUNCT3  in  3  RV32I funct3: 0=B, 1=H, 2=W, 4=BU, 5=HU
- iADDR  in  32  byte address
- iWDATA  in  32  store data (rs2)
- oRDATA  out  32  extended load result, registered, valid while oDONE=1
- oDONE  out  1  one-cycle completion pulse
- oSTALL  out  1  pipeline must hold
- oFAULT  out  1  misaligned or illegal funct3; pulses with oDONE
- oCADDR  out  ADDRW  cache word index
- oCWDATA  out  32  cache write data
- oCRW  out  1  cache direction: 1 = read, 0 = write
- iCRDATA  in  32  cache read data, valid the cycle after the address edge
- iCSTALL  in  1  cache not ready; hold the current step

## Operation
- FSM states: IDLE, RD, WR, DONE.
- IDLE with iREQ=1:
  - Latch address, funct3, wdata and we.
  - Fault check: H/HU/SH with addr[0]=1; W with addr[1:0]≠0; load funct3 ∈ {3,6,7}; store funct3 ≥ 3. A fault goes to DONE with oFAULT=1 and no cache access.
  - Otherwise SW goes to WR. Every other op goes to RD, with oCADDR=iADDR[ADDRW+1:2] driven combinationally this cycle and oCRW=1.
- RD: iCRDATA holds the word.
  - Loads register oRDATA, then go to DONE.
  - Lane select uses addr[1:0] for bytes and addr[1] for halfwords. B/H sign-extend; BU/HU zero-extend.
  - SB/SH merge the iWDATA low byte or halfword into the word at the addressed lane, register the result into the write buffer, then go to WR.
- WR: oCRW=0, oCADDR from the latched address, oCWDATA from the buffer (raw iWDATA for SW). Go to DONE.
- DONE: oDONE=1, oSTALL=0. iREQ is ignored, because it still belongs to the finished instruction. Return to IDLE.
- oSTALL = (IDLE & iREQ) | RD | WR.
- oCRW=1 in every state except WR. An idle cache read is harmless.
- Address bits above ADDRW+1 are ignored, so accesses alias modulo 2^ADDRW words.

## Timing
- Reset values: state IDLE, oRDATA=0, oDONE=0, oFAULT=0, oSTALL=0 (with iREQ=0), oCRW=1, oCADDR=0, oCWDATA=0, latches 0.
- iRSTn low mid-operation aborts immediately. oCRW returns to 1 combinationally, so an in-flight write is suppressed.
- Latency from request to the oDONE cycle, counting edges after the request first appears:
  - Load: 2.
  - SW: 2.
  - SB/SH: 3.
  - Fault: 1.
- Throughput is one op per latency+1 cycles. The DONE cycle is dead.
- iCSTALL=1 freezes the state and all cache-side outputs. The step repeats on the first edge with iCSTALL=0. oDONE is delayed accordingly, and a RD-state capture waits for iCSTALL=0.
- oDONE and oFAULT are single-cycle pulses. oRDATA holds its value until the next load completes.
- Store oRDATA is not updated.

## Structure
- Package rv32_lsu_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - The state encoding (2-bit).
- Sub-module lsu_align_rv32 (combinational) contains:
  - Load lane extract plus sign/zero extension.
  - Store lane merge.
  - The fault decode.
- The FSM and registers live in lsu_rv32.

## Test plan
- **LW:** preload cache word 2 with 0x8899AABB; LW addr 0x08 → oDONE on the 2nd edge, oRDATA=0x8899AABB, oFAULT=0.
- **LB/LBU:** with the same word, LB addr 0x0B → 0xFFFFFF88. LBU addr 0x0B → 0x00000088. LH addr 0x0A → 0xFFFF8899.
- **SB:** word 1 holds 0x11223344; SB addr 0x05, wdata 0xFFFFFFA5 → word 1 becomes 0x1122A544 after 3 edges, and the other words are unchanged.
- **Faults:**
  - LW addr 0x06 → oFAULT=1 and oDONE after 1 edge; oCRW stays 1 throughout, and the cache is unchanged.
  - SH addr 0x03 → same response.
  - Load funct3=3 → same response.
- **iCSTALL:** SW addr 0x0C, 0xDEADBEEF with iCSTALL=1 for 3 cycles during WR → oCRW=0 is held, the write lands after the stall drops, and oDONE is delayed by 3.
- **Reset mid-op:** assert iRSTn=0 in the WR cycle of an SH → no cache write, and all outputs return to their reset values asynchronously. Then test aliasing: LW addr 0x20 reads word 0 (ADDRW=3).
